// File: rtl/axi_rd_pkg.sv
// Shared types and constants for the AXI read master engine.
package axi_rd_pkg;

  localparam int unsigned ID_W_MAX = 16;

  localparam logic [1:0] BURST_FIXED = 2'b00;
  localparam logic [1:0] BURST_INCR  = 2'b01;
  localparam logic [1:0] BURST_WRAP  = 2'b10;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_EXOKAY = 2'b01;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] RESP_DECERR = 2'b11;

  typedef enum logic [0:0] {
    AR_IDLE = 1'b0,
    AR_BUSY = 1'b1
  } ar_state_e;

  // Expected burst shape; id is zero-extended from the instance ID width.
  typedef struct packed {
    logic [ID_W_MAX-1:0] id;
    logic [7:0]          len;
  } trk_entry_t;

endpackage

// File: rtl/axi_rd_tracker_fifo.sv
// In-order synchronous FIFO holding issued-but-incomplete burst descriptors.
module axi_rd_tracker_fifo #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned WIDTH = 12
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             pop,
  output logic [WIDTH-1:0] rd_data_c,
  output logic             full_c,
  output logic             empty_c
);

  localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0]      wr_ptr;
  logic [AW:0]      rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign full_c  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign empty_c = (wr_ptr == rd_ptr);
  assign do_push = push && !full_c;
  assign do_pop  = pop && !empty_c;
  assign rd_data_c = mem[rd_ptr[AW-1:0]];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + (AW+1)'(1);
      if (do_pop)  rd_ptr <= rd_ptr + (AW+1)'(1);
    end
  end

  // Storage needs no reset: entries are only read once the pointers cover them.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr[AW-1:0]] <= wr_data;
  end

endmodule

// File: rtl/axi_master_rd_engine.sv
// Multi-outstanding AXI4 read master: issues AR bursts and checks returning R bursts in order.
module axi_master_rd_engine
  import axi_rd_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH      = 32,
  parameter int unsigned DATA_WIDTH      = 64,
  parameter int unsigned ID_WIDTH        = 4,
  parameter int unsigned MAX_OUTSTANDING = 4
) (
  input  logic                          AClk,
  input  logic                          ARst,
  input  logic                          cmd_valid,
  output logic                          cmd_ready,
  input  logic [ADDR_WIDTH-1:0]         cmd_addr,
  input  logic [ID_WIDTH-1:0]           cmd_id,
  input  logic [7:0]                    cmd_len,
  input  logic [2:0]                    cmd_size,
  input  logic [1:0]                    cmd_burst,
  input  logic [1:0]                    cmd_lock,
  input  logic [3:0]                    cmd_cache,
  input  logic [2:0]                    cmd_prot,
  output logic [ID_WIDTH-1:0]           ARID,
  output logic [ADDR_WIDTH-1:0]         ARADDR,
  output logic [7:0]                    ARLEN,
  output logic [2:0]                    ARSIZE,
  output logic [1:0]                    ARBURST,
  output logic [1:0]                    ARLOCK,
  output logic [3:0]                    ARCACHE,
  output logic [2:0]                    ARPROT,
  output logic                          ARVALID,
  input  logic                          ARREADY,
  input  logic [DATA_WIDTH-1:0]         RDATA,
  input  logic [1:0]                    RRESP,
  input  logic [ID_WIDTH-1:0]           RID,
  input  logic                          RLAST,
  input  logic                          RVALID,
  output logic                          RREADY,
  output logic                          rsp_valid,
  input  logic                          rsp_ready,
  output logic [DATA_WIDTH-1:0]         rsp_data,
  output logic [1:0]                    rsp_resp,
  output logic [ID_WIDTH-1:0]           rsp_id,
  output logic                          rsp_last,
  output logic                          err_last,
  output logic                          err_id,
  output logic [$clog2(MAX_OUTSTANDING):0] outstanding
);

  localparam int unsigned OW    = $clog2(MAX_OUTSTANDING) + 1;
  localparam int unsigned TRK_W = ID_WIDTH + 8;

  ar_state_e             state_q, state_d;
  logic                  arvalid_d;
  logic [ID_WIDTH-1:0]   arid_d;
  logic [ADDR_WIDTH-1:0] araddr_d;
  logic [7:0]            arlen_d;
  logic [2:0]            arsize_d;
  logic [1:0]            arburst_d;
  logic [1:0]            arlock_d;
  logic [3:0]            arcache_d;
  logic [2:0]            arprot_d;

  logic             cmd_ready_c;
  logic             cmd_hs;
  logic             r_hs;
  logic             r_last_hs;
  logic             trk_full;
  logic             trk_empty;
  logic [TRK_W-1:0] trk_rdata;
  trk_entry_t       head;
  logic [8:0]       beat_cnt;

  axi_rd_tracker_fifo #(
    .DEPTH (MAX_OUTSTANDING),
    .WIDTH (TRK_W)
  ) u_tracker (
    .clk       (AClk),
    .rst_n     (ARst),
    .push      (cmd_hs),
    .wr_data   ({cmd_id, cmd_len}),
    .pop       (r_last_hs),
    .rd_data_c (trk_rdata),
    .full_c    (trk_full),
    .empty_c   (trk_empty)
  );

  assign head.id  = ID_W_MAX'(trk_rdata[TRK_W-1:8]);
  assign head.len = trk_rdata[7:0];

  assign cmd_ready_c = (state_q == AR_IDLE) && (outstanding < OW'(MAX_OUTSTANDING)) && !trk_full;
  assign cmd_ready   = cmd_ready_c;
  assign cmd_hs      = cmd_valid && cmd_ready_c;

  // R channel is a zero-latency pass-through gated by the presence of an expected burst.
  assign rsp_valid = RVALID && !trk_empty;
  assign RREADY    = rsp_ready && !trk_empty;
  assign rsp_data  = RDATA;
  assign rsp_resp  = RRESP;
  assign rsp_id    = RID;
  assign rsp_last  = RLAST;
  assign r_hs      = RVALID && RREADY;
  assign r_last_hs = r_hs && RLAST;

  always_comb begin
    state_d   = state_q;
    arvalid_d = ARVALID;
    arid_d    = ARID;
    araddr_d  = ARADDR;
    arlen_d   = ARLEN;
    arsize_d  = ARSIZE;
    arburst_d = ARBURST;
    arlock_d  = ARLOCK;
    arcache_d = ARCACHE;
    arprot_d  = ARPROT;
    case (state_q)
      AR_IDLE: begin
        if (cmd_hs) begin
          arvalid_d = 1'b1;
          arid_d    = cmd_id;
          araddr_d  = cmd_addr;
          arlen_d   = cmd_len;
          arsize_d  = cmd_size;
          arburst_d = cmd_burst;
          arlock_d  = cmd_lock;
          arcache_d = cmd_cache;
          arprot_d  = cmd_prot;
          state_d   = AR_BUSY;
        end
      end
      AR_BUSY: begin
        if (ARREADY) begin
          arvalid_d = 1'b0;
          state_d   = AR_IDLE;
        end
      end
      default: begin
        arvalid_d = 1'b0;
        state_d   = AR_IDLE;
      end
    endcase
  end

  always_ff @(posedge AClk or negedge ARst) begin
    if (!ARst) begin
      state_q <= AR_IDLE;
      ARVALID <= 1'b0;
      ARID    <= '0;
      ARADDR  <= '0;
      ARLEN   <= '0;
      ARSIZE  <= '0;
      ARBURST <= '0;
      ARLOCK  <= '0;
      ARCACHE <= '0;
      ARPROT  <= '0;
    end else begin
      state_q <= state_d;
      ARVALID <= arvalid_d;
      ARID    <= arid_d;
      ARADDR  <= araddr_d;
      ARLEN   <= arlen_d;
      ARSIZE  <= arsize_d;
      ARBURST <= arburst_d;
      ARLOCK  <= arlock_d;
      ARCACHE <= arcache_d;
      ARPROT  <= arprot_d;
    end
  end

  // Burst accounting and in-order shape/ID checking against the tracker head.
  always_ff @(posedge AClk or negedge ARst) begin
    if (!ARst) begin
      outstanding <= '0;
      beat_cnt    <= '0;
      err_last    <= 1'b0;
      err_id      <= 1'b0;
    end else begin
      case ({cmd_hs, r_last_hs})
        2'b10:   outstanding <= outstanding + OW'(1);
        2'b01:   outstanding <= outstanding - OW'(1);
        default: outstanding <= outstanding;
      endcase
      if (r_last_hs)  beat_cnt <= '0;
      else if (r_hs)  beat_cnt <= beat_cnt + 9'd1;
      err_last <= r_hs && (RLAST ? (beat_cnt != {1'b0, head.len})
                                 : (beat_cnt == {1'b0, head.len}));
      err_id   <= r_hs && (ID_W_MAX'(RID) != head.id);
    end
  end

endmodule

// File: tb/tb_axi_master_rd_engine.sv
// Directed, table-driven bench for axi_master_rd_engine.
module tb_axi_master_rd_engine;
  import axi_rd_pkg::*;

  logic        AClk = 1'b0;
  logic        ARst;
  logic        cmd_valid, cmd_ready;
  logic [31:0] cmd_addr;
  logic [3:0]  cmd_id;
  logic [7:0]  cmd_len;
  logic [2:0]  cmd_size;
  logic [1:0]  cmd_burst, cmd_lock;
  logic [3:0]  cmd_cache;
  logic [2:0]  cmd_prot;
  logic [3:0]  ARID;
  logic [31:0] ARADDR;
  logic [7:0]  ARLEN;
  logic [2:0]  ARSIZE;
  logic [1:0]  ARBURST, ARLOCK;
  logic [3:0]  ARCACHE;
  logic [2:0]  ARPROT;
  logic        ARVALID, ARREADY;
  logic [63:0] RDATA;
  logic [1:0]  RRESP;
  logic [3:0]  RID;
  logic        RLAST, RVALID, RREADY;
  logic        rsp_valid, rsp_ready;
  logic [63:0] rsp_data;
  logic [1:0]  rsp_resp;
  logic [3:0]  rsp_id;
  logic        rsp_last, err_last, err_id;
  logic [2:0]  outstanding;

  int errors = 0;
  int checks = 0;

  axi_master_rd_engine dut (
    .AClk(AClk), .ARst(ARst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_addr(cmd_addr), .cmd_id(cmd_id),
    .cmd_len(cmd_len), .cmd_size(cmd_size), .cmd_burst(cmd_burst), .cmd_lock(cmd_lock),
    .cmd_cache(cmd_cache), .cmd_prot(cmd_prot),
    .ARID(ARID), .ARADDR(ARADDR), .ARLEN(ARLEN), .ARSIZE(ARSIZE), .ARBURST(ARBURST),
    .ARLOCK(ARLOCK), .ARCACHE(ARCACHE), .ARPROT(ARPROT), .ARVALID(ARVALID), .ARREADY(ARREADY),
    .RDATA(RDATA), .RRESP(RRESP), .RID(RID), .RLAST(RLAST), .RVALID(RVALID), .RREADY(RREADY),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data), .rsp_resp(rsp_resp),
    .rsp_id(rsp_id), .rsp_last(rsp_last), .err_last(err_last), .err_id(err_id),
    .outstanding(outstanding)
  );

  always #5 AClk = ~AClk;

  initial begin
    #1ms;
    $display("FAIL watchdog: simulation did not finish, errors=%0d", errors);
    $fatal(1, "watchdog");
  end

  typedef struct {
    logic [3:0] rid;
    logic       rlast;
    logic [63:0] data;
    logic       exp_err_last;
    logic       exp_err_id;
  } beat_vec_t;

  beat_vec_t vecs [13];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge AClk);
    #1;
  endtask

  task automatic send_cmd(input logic [31:0] addr, input logic [3:0] id, input logic [7:0] len);
    cmd_valid = 1'b1; cmd_addr = addr; cmd_id = id; cmd_len = len;
    cmd_size = 3'd3; cmd_burst = BURST_INCR; cmd_lock = 2'd0; cmd_cache = 4'h3; cmd_prot = 3'd0;
    for (int i = 0; i < 50 && !cmd_ready; i++) tick();
    if (!cmd_ready) begin
      checks++; errors++;
      $display("FAIL cmd_timeout: cmd_ready got 0 expected 1 (id %0d)", id);
    end
    tick();
    cmd_valid = 1'b0;
  endtask

  task automatic ar_accept(input int delay);
    for (int i = 0; i < 50 && !ARVALID; i++) tick();
    check("ar_wait_valid", 64'(ARVALID), 64'd1);
    for (int i = 0; i < delay; i++) begin
      tick();
      check("ar_hold_valid", 64'(ARVALID), 64'd1);
    end
    ARREADY = 1'b1;
    tick();
    ARREADY = 1'b0;
    check("ar_drop_valid", 64'(ARVALID), 64'd0);
  endtask

  task automatic drive_beat(input logic [3:0] id, input logic last, input logic [63:0] data,
                            input logic exp_el, input logic exp_ei);
    RVALID = 1'b1; RID = id; RLAST = last; RDATA = data; RRESP = RESP_OKAY; rsp_ready = 1'b1;
    #1;
    check("beat_rready", 64'(RREADY), 64'd1);
    check("beat_data", rsp_data, data);
    tick();
    RVALID = 1'b0; RLAST = 1'b0;
    check("beat_err_last", 64'(err_last), 64'(exp_el));
    check("beat_err_id", 64'(err_id), 64'(exp_ei));
  endtask

  task automatic burst(input logic [3:0] id, input int len);
    for (int b = 0; b <= len; b++)
      drive_beat(id, b == len, {56'h0, id, 4'(b)}, 1'b0, 1'b0);
  endtask

  initial begin
    ARst = 1'b0; cmd_valid = 1'b0; cmd_addr = '0; cmd_id = '0; cmd_len = '0; cmd_size = '0;
    cmd_burst = '0; cmd_lock = '0; cmd_cache = '0; cmd_prot = '0; ARREADY = 1'b0;
    RDATA = '0; RRESP = '0; RID = '0; RLAST = 1'b0; RVALID = 1'b0; rsp_ready = 1'b0;

    // Reset values
    tick(); tick();
    check("rst_arvalid", 64'(ARVALID), 64'd0);
    check("rst_araddr", 64'(ARADDR), 64'd0);
    check("rst_arid", 64'(ARID), 64'd0);
    check("rst_rready", 64'(RREADY), 64'd0);
    check("rst_rsp_valid", 64'(rsp_valid), 64'd0);
    check("rst_err", 64'({err_last, err_id}), 64'd0);
    check("rst_outstanding", 64'(outstanding), 64'd0);
    ARst = 1'b1;
    tick();
    check("rst_cmd_ready", 64'(cmd_ready), 64'd1);

    // Single beat with delayed ARREADY
    send_cmd(32'h1000, 4'd3, 8'd0);
    check("t1_arvalid", 64'(ARVALID), 64'd1);
    check("t1_arlen", 64'(ARLEN), 64'd0);
    check("t1_arid", 64'(ARID), 64'd3);
    check("t1_arburst", 64'(ARBURST), 64'(BURST_INCR));
    check("t1_outstanding", 64'(outstanding), 64'd1);
    check("t1_cmd_ready_busy", 64'(cmd_ready), 64'd0);
    tick(); tick();
    check("t1_araddr_held", 64'(ARADDR), 64'h1000);
    ar_accept(0);
    RVALID = 1'b1; RLAST = 1'b1; RID = 4'd3; RDATA = 64'hDEAD_BEEF_0000_0001; rsp_ready = 1'b1;
    #1;
    check("t1_rsp_valid", 64'(rsp_valid), 64'd1);
    check("t1_rsp_last", 64'(rsp_last), 64'd1);
    check("t1_rsp_data", rsp_data, 64'hDEAD_BEEF_0000_0001);
    tick();
    RVALID = 1'b0; RLAST = 1'b0;
    check("t1_outstanding_done", 64'(outstanding), 64'd0);
    check("t1_err", 64'({err_last, err_id}), 64'd0);
    check("t1_rready_empty", 64'(RREADY), 64'd0);

    // Outstanding limit
    for (int i = 0; i < 4; i++) begin
      send_cmd(32'h2000 + 32'(i * 64), 4'(i), 8'd3);
      ar_accept(0);
    end
    check("t2_outstanding_full", 64'(outstanding), 64'd4);
    check("t2_cmd_ready_full", 64'(cmd_ready), 64'd0);
    cmd_valid = 1'b1; cmd_id = 4'd4; cmd_len = 8'd3; cmd_addr = 32'h2100;
    tick(); tick();
    check("t2_no_5th_ar", 64'(ARVALID), 64'd0);
    burst(4'd0, 3);
    check("t2_cmd_ready_after_rlast", 64'(cmd_ready), 64'd1);
    check("t2_outstanding_after_rlast", 64'(outstanding), 64'd3);
    tick();
    cmd_valid = 1'b0;
    check("t2_5th_arvalid", 64'(ARVALID), 64'd1);
    check("t2_5th_arid", 64'(ARID), 64'd4);
    ar_accept(0);
    for (int i = 1; i < 5; i++) burst(4'(i), 3);
    check("t2_drained", 64'(outstanding), 64'd0);

    // Backpressure, 16 beats
    send_cmd(32'h3000, 4'd1, 8'd15);
    ar_accept(0);
    begin
      int n = 0;
      for (int c = 0; c < 100 && n < 16; c++) begin
        rsp_ready = (c % 2 == 0);
        RVALID = 1'b1; RID = 4'd1; RLAST = (n == 15); RDATA = 64'hB000 + 64'(n);
        #1;
        check("t3_rready_mirror", 64'(RREADY), 64'(rsp_ready));
        if (rsp_ready) check("t3_data_order", rsp_data, 64'hB000 + 64'(n));
        tick();
        if (rsp_ready) n++;
      end
      RVALID = 1'b0; RLAST = 1'b0; rsp_ready = 1'b1;
      check("t3_beats", 64'(n), 64'd16);
    end
    check("t3_err", 64'({err_last, err_id}), 64'd0);
    check("t3_beat_cnt", 64'(dut.beat_cnt), 64'd0);
    check("t3_outstanding", 64'(outstanding), 64'd0);

    // Early RLAST, long burst, ID mismatch: table-driven
    vecs[0]  = '{4'd6, 1'b0, 64'h60, 1'b0, 1'b0};
    vecs[1]  = '{4'd6, 1'b0, 64'h61, 1'b0, 1'b0};
    vecs[2]  = '{4'd6, 1'b0, 64'h62, 1'b0, 1'b0};
    vecs[3]  = '{4'd6, 1'b0, 64'h63, 1'b0, 1'b0};
    vecs[4]  = '{4'd6, 1'b0, 64'h64, 1'b0, 1'b0};
    vecs[5]  = '{4'd6, 1'b1, 64'h65, 1'b1, 1'b0};
    vecs[6]  = '{4'd7, 1'b0, 64'h70, 1'b0, 1'b0};
    vecs[7]  = '{4'd7, 1'b1, 64'h71, 1'b0, 1'b0};
    vecs[8]  = '{4'd5, 1'b0, 64'h20, 1'b0, 1'b1};
    vecs[9]  = '{4'd2, 1'b1, 64'h21, 1'b0, 1'b0};
    vecs[10] = '{4'd1, 1'b0, 64'h10, 1'b0, 1'b0};
    vecs[11] = '{4'd1, 1'b0, 64'h11, 1'b1, 1'b0};
    vecs[12] = '{4'd1, 1'b1, 64'h12, 1'b1, 1'b0};
    send_cmd(32'h4000, 4'd6, 8'd7); ar_accept(0);
    send_cmd(32'h4100, 4'd7, 8'd1); ar_accept(0);
    send_cmd(32'h4200, 4'd2, 8'd1); ar_accept(0);
    send_cmd(32'h4300, 4'd1, 8'd1); ar_accept(0);
    for (int v = 0; v < 13; v++)
      drive_beat(vecs[v].rid, vecs[v].rlast, vecs[v].data, vecs[v].exp_err_last, vecs[v].exp_err_id);
    tick();
    check("t4_err_clears", 64'({err_last, err_id}), 64'd0);
    check("t4_outstanding", 64'(outstanding), 64'd0);

    // Command accept coinciding with RLAST handshake
    send_cmd(32'h5000, 4'd3, 8'd0);
    ar_accept(0);
    cmd_valid = 1'b1; cmd_id = 4'd4; cmd_len = 8'd0; cmd_addr = 32'h5100;
    RVALID = 1'b1; RLAST = 1'b1; RID = 4'd3; RDATA = 64'h5; rsp_ready = 1'b1;
    #1;
    check("t5_cmd_ready", 64'(cmd_ready), 64'd1);
    check("t5_rready", 64'(RREADY), 64'd1);
    tick();
    cmd_valid = 1'b0; RVALID = 1'b0; RLAST = 1'b0;
    check("t5_outstanding_same", 64'(outstanding), 64'd1);
    check("t5_arid", 64'(ARID), 64'd4);
    ar_accept(0);
    drive_beat(4'd4, 1'b1, 64'h6, 1'b0, 1'b0);
    check("t5_outstanding_done", 64'(outstanding), 64'd0);

    // Reset mid-burst
    send_cmd(32'h6000, 4'd2, 8'd7); ar_accept(0);
    send_cmd(32'h6100, 4'd3, 8'd0);
    check("t6_pending_ar", 64'(ARVALID), 64'd1);
    for (int b = 0; b < 3; b++) drive_beat(4'd2, 1'b0, 64'(b), 1'b0, 1'b0);
    RVALID = 1'b1; RID = 4'd2; rsp_ready = 1'b1;
    ARst = 1'b0;
    #1;
    check("t6_arvalid", 64'(ARVALID), 64'd0);
    check("t6_araddr", 64'(ARADDR), 64'd0);
    check("t6_rready", 64'(RREADY), 64'd0);
    check("t6_rsp_valid", 64'(rsp_valid), 64'd0);
    check("t6_outstanding", 64'(outstanding), 64'd0);
    tick();
    RVALID = 1'b0;
    ARst = 1'b1;
    tick();
    check("t6_cmd_ready", 64'(cmd_ready), 64'd1);
    send_cmd(32'h7000, 4'd9, 8'd0);
    ar_accept(0);
    drive_beat(4'd9, 1'b1, 64'h99, 1'b0, 1'b0);
    check("t6_outstanding_done", 64'(outstanding), 64'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/axi_master_rd_engine.md
# axi_master_rd_engine

Parametrised successor to the single-transaction AXI read master. It accepts read commands from the decoder over a valid/ready port and issues them on the AXI AR channel. Up to `MAX_OUTSTANDING` bursts may be in flight at once. R beats return to the decoder with backpressure, and the block checks each burst's RLAST position and RID against the issued command, in order.

## Interface
Parameters:
- `ADDR_WIDTH`, 32, AXI address width
- `DATA_WIDTH`, 64, RDATA width
- `ID_WIDTH`, 4, transaction ID width (ARID/RID)
- `MAX_OUTSTANDING`, 4, in-flight burst limit; power of two, 2..16

Ports:
- `AClk` in 1: clock, all logic on rising edge
- `ARst` in 1: reset, asynchronous assert, active-low
- `cmd_valid` in 1: decoder command valid
- `cmd_ready` out 1: command accepted when valid&ready
- `cmd_addr` in ADDR_WIDTH: start address
- `cmd_id` in ID_WIDTH: transaction ID
- `cmd_len` in 8: AXI4 ARLEN (beats-1, 0..255)
- `cmd_size` in 3, `cmd_burst` in 2, `cmd_lock` in 2, `cmd_cache` in 4, `cmd_prot` in 3: burst attributes
- `ARID` out ID_WIDTH; `ARADDR` out ADDR_WIDTH; `ARLEN` out 8; `ARSIZE` out 3; `ARBURST` out 2; `ARLOCK` out 2; `ARCACHE` out 4; `ARPROT` out 3: AR payload
- `ARVALID` out 1; `ARREADY` in 1: AR handshake
- `RDATA` in DATA_WIDTH; `RRESP` in 2; `RID` in ID_WIDTH; `RLAST` in 1: R payload
- `RVALID` in 1; `RREADY` out 1: R handshake
- `rsp_valid` out 1; `rsp_ready` in 1: decoder response handshake
- `rsp_data` out DATA_WIDTH; `rsp_resp` out 2; `rsp_id` out ID_WIDTH; `rsp_last` out 1: response payload
- `err_last` out 1: one-cycle pulse on RLAST position mismatch
- `err_id` out 1: one-cycle pulse on RID ≠ expected ID
- `outstanding` out $clog2(MAX_OUTSTANDING)+1: bursts issued and not yet completed

## Operation
- Reset values: ARVALID=0, all AR payload outputs=0, RREADY=0, rsp_valid=0, err_*=0, outstanding=0, tracker empty, beat counter=0. No Z drive anywhere.
- **AR FSM, state AR_IDLE:**
  - `cmd_ready` = 1 when `outstanding` < MAX_OUTSTANDING.
  - On a command handshake: register the payload into the AR outputs, set ARVALID=1, push {id, len} into the tracker, go to AR_BUSY.
- **AR FSM, state AR_BUSY:**
  - `cmd_ready` = 0; AR payload held stable.
  - On ARVALID&ARREADY: ARVALID=0, return to AR_IDLE.
- `outstanding` increments on command accept and decrements on the RLAST handshake. If both occur in the same cycle, it is unchanged.
- **Tracker:** in-order FIFO, depth MAX_OUTSTANDING, width ID_WIDTH+8. The head entry is the expected {id, len} for the current R burst.
- **R path (combinational pass-through):**
  - `rsp_valid` = RVALID & ~tracker_empty.
  - `RREADY` = rsp_ready & ~tracker_empty.
  - `rsp_data`, `rsp_resp`, `rsp_id`, `rsp_last` = RDATA, RRESP, RID, RLAST.
- **Beat counter (9 bits):** increments on each R handshake and clears to 0 on the RLAST handshake.
- **err_last** pulses on either of:
  - RLAST handshake with beat_cnt ≠ head.len;
  - non-RLAST handshake with beat_cnt == head.len.
- **err_id** pulses on any R handshake with RID ≠ head.id.
- The tracker pops on the RLAST handshake only. A long burst therefore keeps flagging `err_last` until RLAST arrives.
- RRESP is passed through unchanged and never alters the FSM.

## Timing
- Command accept at edge N → ARVALID=1 after edge N. Minimum 1-cycle command-to-AR latency.
- Maximum AR issue rate is one burst per 2 cycles.
- ARVALID is never deasserted before the ARREADY handshake, and the AR payload does not change while ARVALID=1.
- R path has zero latency. A beat transfers in the same cycle RVALID&RREADY is sampled, giving one beat per cycle when rsp_ready stays 1.
- `err_*` are registered: they assert for exactly 1 cycle, the cycle after the offending beat.
- R beats may arrive in the cycle after the AR handshake. The tracker entry exists from command accept, so RREADY can already be 1 then.
- When the tracker is full, `cmd_ready`=0 until an RLAST handshake. `cmd_ready` rises the cycle after that handshake.
- Asynchronous reset mid-burst: all state clears immediately, in-flight bursts are discarded, and outputs go to their reset values while ARst=0.

## Structure
- Shared package `axi_rd_pkg`:
  - burst type constants FIXED/INCR/WRAP;
  - RRESP constants OKAY/EXOKAY/SLVERR/DECERR;
  - AR FSM state encoding;
  - tracker entry struct {id, len}.
- One sub-module `axi_rd_tracker_fifo` (parametrised depth/width synchronous FIFO with full/empty flags) instantiated for the tracker. Counter and FSM logic are inline.

## Test plan
- Single beat: cmd addr=0x1000, id=3, len=0, INCR; ARREADY after 2 cycles; one R beat with RLAST=1 → ARLEN=0, ARADDR held through the wait, rsp_last=1, outstanding returns 0, no errors.
- Outstanding limit: 5 cmds (len=3) back-to-back with R withheld → 4 AR handshakes and `cmd_ready`=0. Return the first burst's 4 beats → `cmd_ready`=1 the cycle after that burst's RLAST, then the 5th AR issues.
- Backpressure: 16-beat burst with rsp_ready toggling every cycle → RREADY mirrors rsp_ready, all 16 data words delivered in order, beat counter 0 after RLAST.
- Early RLAST: len=7, slave asserts RLAST on beat 5 → err_last pulses once, tracker pops, next burst checked normally.
- ID mismatch plus simultaneous events: RID=5 while head.id=2 → err_id pulse. Separately, a cmd accept in the same cycle as an RLAST handshake leaves `outstanding` unchanged.
- Reset mid-burst: assert ARst on beat 3 of len=7 → ARVALID, RREADY, rsp_valid and outstanding all 0 immediately. After release, a new cmd completes cleanly.
